tilemap_sequencer: RTL and testbench

Upstream stage of the tile drawer. Scans a MAP_COLS × MAP_ROWS tile map held in a synchronous map RAM in row-major order. For each map entry it issues one tile-draw request (tile base address plus pixel origin) to the tile drawer, then waits for that drawer to finish before moving on. Entries equal to SKIP_CODE are not drawn. One `start` pulse redraws the whole screen.

---
 rtl/tilemap_sequencer.sv | 173 +++++++++++++++++
 tb/tb_tilemap_sequencer.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tilemap_sequencer.sv
// tilemap_sequencer
//   Walks a MAP_COLS x MAP_ROWS tile map in row-major order. It reads each
//   entry from a synchronous map RAM and issues one draw request per
//   non-skip entry. It then waits for the tile drawer to finish before
//   moving on to the next entry.
//
// Ports
//   clk, reset      system clock, synchronous active-high reset
//   start           one-cycle request to sequence the whole map (IDLE only)
//   abort           level; end the pass at the next ADVANCE
//   map_addr        map RAM read address (row*MAP_COLS + col)
//   map_data        map RAM read data, valid one cycle after map_addr
//   tile_address    tile ROM base address for the drawer
//   x_pos, y_pos    pixel origin of the tile
//   draw            one-cycle draw strobe
//   drawer_active   drawer busy flag
//   busy            high while not IDLE
//   done            one-cycle pulse at the end of every pass
//   timeout_err     sticky drawer-acknowledge timeout flag
module tilemap_sequencer #(
    parameter int         MAP_COLS    = 20,
    parameter int         MAP_ROWS    = 15,
    parameter int         TILE_PX     = 8,
    parameter logic [7:0] SKIP_CODE   = 8'hFF,
    parameter int         ACK_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       abort,
    output logic [8:0] map_addr,
    input  logic [7:0] map_data,
    output logic [7:0] tile_address,
    output logic [7:0] x_pos,
    output logic [7:0] y_pos,
    output logic       draw,
    input  logic       drawer_active,
    output logic       busy,
    output logic       done,
    output logic       timeout_err
);

    localparam int COL_W = (MAP_COLS > 1) ? $clog2(MAP_COLS) : 1;
    localparam int ROW_W = (MAP_ROWS > 1) ? $clog2(MAP_ROWS) : 1;
    localparam int PX_SH = $clog2(TILE_PX);
    localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(MAP_COLS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MAP_ROWS - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        WAIT_RAM,
        CHECK,
        ISSUE,
        WAIT_ACK,
        WAIT_DONE,
        ADVANCE,
        FINISH
    } state_t;

    state_t           state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic [7:0]       entry;
    logic [CNT_W-1:0] ack_cnt;

    // Pixel origin = tile index scaled by the tile edge, kept to 8 bits.
    logic [15:0] x_wide;
    logic [15:0] y_wide;

    always_comb begin
        x_wide = 16'(col) << PX_SH;
        y_wide = 16'(row) << PX_SH;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            col          <= '0;
            row          <= '0;
            entry        <= '0;
            ack_cnt      <= '0;
            map_addr     <= '0;
            tile_address <= '0;
            x_pos        <= '0;
            y_pos        <= '0;
            draw         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            draw <= 1'b0;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        col         <= '0;
                        row         <= '0;
                        map_addr    <= '0;
                        timeout_err <= 1'b0;
                        busy        <= 1'b1;
                        state       <= FETCH;
                    end
                end
                FETCH: begin
                    state <= WAIT_RAM;
                end
                WAIT_RAM: begin
                    entry <= map_data;
                    state <= CHECK;
                end
                CHECK: begin
                    if (entry == SKIP_CODE) begin
                        state <= ADVANCE;
                    end else begin
                        tile_address <= entry;
                        x_pos        <= x_wide[7:0];
                        y_pos        <= y_wide[7:0];
                        draw         <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    ack_cnt <= '0;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (drawer_active) begin
                        state <= WAIT_DONE;
                    end else begin
                        ack_cnt <= ack_cnt + 1'b1;
                        // The counter is about to reach ACK_TIMEOUT, so abandon the tile.
                        if (ack_cnt == LAST_CNT) begin
                            timeout_err <= 1'b1;
                            state       <= ADVANCE;
                        end
                    end
                end
                WAIT_DONE: begin
                    if (!drawer_active) begin
                        state <= ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (abort || (col == LAST_COL && row == LAST_ROW)) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        if (col == LAST_COL) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        map_addr <= map_addr + 9'd1;
                        state    <= FETCH;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tilemap_sequencer.sv
// tb_tilemap_sequencer
//   Randomised bench for tilemap_sequencer. It models the map RAM and the
//   tile drawer. The expected draw list is derived directly from map
//   contents, and pass lengths come from per-tile cycle costs.
module tb_tilemap_sequencer;

    localparam int COLS   = 20;
    localparam int ROWS   = 15;
    localparam int N      = COLS * ROWS;
    localparam int ACK_TO = 15;
    localparam int LIMIT  = 20000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [8:0] map_addr;
    logic [7:0] map_data = '0;
    logic [7:0] tile_address;
    logic [7:0] x_pos;
    logic [7:0] y_pos;
    logic       draw;
    logic       drawer_active = 1'b0;
    logic       busy;
    logic       done;
    logic       timeout_err;

    tilemap_sequencer #(
        .MAP_COLS(COLS),
        .MAP_ROWS(ROWS),
        .TILE_PX(8),
        .SKIP_CODE(8'hFF),
        .ACK_TIMEOUT(ACK_TO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .map_addr(map_addr),
        .map_data(map_data),
        .tile_address(tile_address),
        .x_pos(x_pos),
        .y_pos(y_pos),
        .draw(draw),
        .drawer_active(drawer_active),
        .busy(busy),
        .done(done),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    typedef struct {
        logic [7:0] tile;
        logic [7:0] x;
        logic [7:0] y;
        logic [8:0] addr;
    } draw_t;

    logic [7:0] mem [N];
    draw_t      exp_q [$];
    int         busy_len = 2;
    int         done_cnt = 0;

    // Expected draws: every non-skip entry in scan order, optionally capped.
    task automatic build_expected(input int limit);
        draw_t e;
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            if (mem[i] != 8'hFF && exp_q.size() < limit) begin
                e.tile = mem[i];
                e.x    = 8'((i % COLS) * 8);
                e.y    = 8'((i / COLS) * 8);
                e.addr = 9'(i);
                exp_q.push_back(e);
            end
        end
    endtask

    // Cycles from the start-sampling cycle to the done cycle.
    // skip = 4, drawn = 4 + 1 + (b-1) + 1, timed out = 4 + ACK_TO + 1, plus FINISH.
    function automatic int exp_len(input int b);
        int t = 1;
        for (int i = 0; i < N; i++) begin
            if (mem[i] == 8'hFF) t += 4;
            else if (b == 0)     t += 4 + ACK_TO + 1;
            else                 t += b + 5;
        end
        return t;
    endfunction

    task automatic fill_all(input logic [7:0] v);
        for (int i = 0; i < N; i++) mem[i] = v;
    endtask

    task automatic fill_random(input int pct);
        for (int i = 0; i < N; i++)
            mem[i] = ($urandom_range(0, 99) < pct) ? 8'($urandom_range(0, 254)) : 8'hFF;
    endtask

    // Map RAM, drawer model and draw monitor, all evaluated on the falling edge.
    initial begin : models
        logic [8:0] ram_addr_q;
        int         act_cnt;
        logic       held_valid;
        logic [7:0] h_tile, h_x, h_y;
        draw_t      e;
        ram_addr_q = '0;
        act_cnt    = 0;
        held_valid = 1'b0;
        h_tile = '0; h_x = '0; h_y = '0;
        forever begin
            @(negedge clk);
            if (reset) held_valid = 1'b0;
            if (done) done_cnt++;
            if (draw) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_draw", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("draw_tile", tile_address, e.tile);
                    check("draw_x", x_pos, e.x);
                    check("draw_y", y_pos, e.y);
                    check("draw_map_addr", map_addr, e.addr);
                end
                h_tile = tile_address; h_x = x_pos; h_y = y_pos;
                held_valid = 1'b1;
            end else if (drawer_active && held_valid) begin
                check("hold_tile", tile_address, h_tile);
                check("hold_x", x_pos, h_x);
                check("hold_y", y_pos, h_y);
            end
            map_data   = (ram_addr_q < 9'(N)) ? mem[ram_addr_q] : 8'h00;
            ram_addr_q = map_addr;
            if (draw && busy_len > 0) begin
                drawer_active = 1'b1;
                act_cnt       = busy_len;
            end else if (drawer_active) begin
                act_cnt--;
                if (act_cnt <= 0) drawer_active = 1'b0;
            end
        end
    end

    // One pass: start is sampled in cycle 0 and k counts cycles after it.
    task automatic run_pass(input bit rand_start, input bit do_abort, input int exp_cycles,
                            output int done_k, output int first_draw_k, output int te_k,
                            output int fall_k, output logic [8:0] addr_at_done);
        int draws;
        int dc0;
        draws = 0; done_k = -1; first_draw_k = -1; te_k = -1; fall_k = -1;
        addr_at_done = '0;
        dc0 = done_cnt;
        @(negedge clk); #1;
        start = 1'b1;
        for (int k = 1; k <= LIMIT; k++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (k == 1) check("err_clear_on_start", timeout_err, 0);
            if (draw) begin
                draws++;
                if (first_draw_k < 0) first_draw_k = k;
            end
            if (timeout_err && te_k < 0) te_k = k;
            if (do_abort && draws == 6 && drawer_active) abort = 1'b1;
            if (abort && !drawer_active && fall_k < 0) fall_k = k;
            if (done) begin
                done_k       = k;
                addr_at_done = map_addr;
                check("busy_during_done", busy, 1);
                break;
            end
            if (rand_start && k >= 2) start = ($urandom_range(0, 5) == 0);
        end
        start = 1'b0;
        abort = 1'b0;
        if (done_k < 0) check("pass_cycle_budget", 0, 1);
        if (exp_cycles > 0) check("pass_length", done_k, exp_cycles);
        @(negedge clk); #1;
        check("busy_after_done", busy, 0);
        check("done_single_pulse", done, 0);
        repeat (3) @(negedge clk);
        #1;
        check("done_count", done_cnt - dc0, 1);
        check("missed_draws", exp_q.size(), 0);
    endtask

    initial begin : main
        int dk, fk, tk, lk;
        logic [8:0] ad;
        bit reached;

        repeat (3) @(negedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk); #1;
        check("rst_map_addr", map_addr, 0);
        check("rst_tile", tile_address, 0);
        check("rst_x", x_pos, 0);
        check("rst_y", y_pos, 0);
        check("rst_draw", draw, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", timeout_err, 0);

        // All-skip map.
        fill_all(8'hFF);
        busy_len = 3;
        build_expected(N);
        run_pass(1'b0, 1'b0, 1201, dk, fk, tk, lk, ad);
        check("skip_no_draw", fk, -1);
        check("skip_final_addr", ad, 299);

        // Single tile at (3,2) with a long drawer.
        fill_all(8'hFF);
        mem[2 * COLS + 3] = 8'h40;
        busy_len = 200;
        build_expected(N);
        run_pass(1'b0, 1'b0, exp_len(200), dk, fk, tk, lk, ad);

        // Row wrap: (19,0) then (0,1).
        fill_all(8'hFF);
        mem[19] = 8'($urandom_range(0, 254));
        mem[20] = 8'($urandom_range(0, 254));
        busy_len = 4;
        build_expected(N);
        run_pass(1'b0, 1'b0, exp_len(4), dk, fk, tk, lk, ad);

        // Random maps, random start pulses while busy.
        for (int p = 0; p < 3; p++) begin
            fill_random($urandom_range(5, 40));
            mem[0]   = 8'($urandom_range(0, 254));
            busy_len = $urandom_range(2, 6);
            build_expected(N);
            run_pass(1'b1, 1'b0, exp_len(busy_len), dk, fk, tk, lk, ad);
            check("first_draw_latency", fk, 4);
        end

        // Drawer never acknowledges. The error is loaded at the end of the
        // 15th WAIT_ACK cycle, so it is first seen 16 cycles after draw.
        fill_all(8'hFF);
        mem[0] = 8'h12;
        mem[7] = 8'h34;
        busy_len = 0;
        build_expected(N);
        run_pass(1'b0, 1'b0, exp_len(0), dk, fk, tk, lk, ad);
        check("timeout_rise", tk, fk + 16);
        check("timeout_sticky", timeout_err, 1);
        fill_all(8'hFF);
        busy_len = 3;
        build_expected(N);
        run_pass(1'b0, 1'b0, 1201, dk, fk, tk, lk, ad);
        check("timeout_cleared", timeout_err, 0);

        // Abort during the drawer busy time of tile 5 (sixth draw).
        fill_random(30);
        for (int i = 0; i < 10; i++) mem[i] = 8'($urandom_range(0, 254));
        busy_len = 10;
        build_expected(6);
        run_pass(1'b0, 1'b1, -1, dk, fk, tk, lk, ad);
        check("abort_done_delay", dk, lk + 2);

        // Reset while the drawer is busy.
        fill_all(8'hFF);
        mem[0] = 8'h55;
        busy_len = 50;
        build_expected(N);
        @(negedge clk); #1;
        start = 1'b1;
        reached = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk); #1;
            start = 1'b0;
            if (drawer_active && k >= 8) begin
                reached = 1'b1;
                break;
            end
        end
        check("reach_wait_done", reached, 1);
        reset = 1'b1;
        @(negedge clk); #1;
        check("mid_rst_map_addr", map_addr, 0);
        check("mid_rst_tile", tile_address, 0);
        check("mid_rst_x", x_pos, 0);
        check("mid_rst_y", y_pos, 0);
        check("mid_rst_draw", draw, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_err", timeout_err, 0);
        @(negedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
        reached = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (!drawer_active) begin
                reached = 1'b1;
                break;
            end
            @(negedge clk); #1;
        end
        check("drawer_finished", reached, 1);
        fill_random(20);
        mem[0] = 8'($urandom_range(0, 254));
        busy_len = 5;
        build_expected(N);
        run_pass(1'b0, 1'b0, exp_len(5), dk, fk, tk, lk, ad);
        check("restart_first_draw", fk, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
